uart_loopback_seq: RTL and testbench

UART_LOOPBACK_SEQ -- requirements
Module: uart_loopback_seq

---
 rtl/uart_loopback_seq.sv | 185 ++++++++++++++++++
 tb/tb_uart_loopback_seq.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_loopback_seq.sv
// UART loopback sequencer: sends NUM_BYTES pattern bytes to a tx_module,
// compares what the rx_module returns, counts errors and reports Pass.
//
// Ports:
//   CLK, RST_n            clock, asynchronous active-low reset
//   Start_Sig             level, sampled only while idle
//   Tx_En_Sig, Tx_Data    transmit request and byte to the tx_module
//   Tx_Done_Sig           tx_module completion pulse
//   Rx_Done_Sig, Rx_Data  rx_module byte-valid pulse and byte
//   Busy, Done_Sig, Pass  status, end-of-run pulse, last-run verdict
//   Err_Cnt, Byte_Cnt     saturating error count, bytes completed
//   Timeout_Err           sticky per-run timeout flag
module uart_loopback_seq #(
    parameter int unsigned       DATA_W       = 8,
    parameter int unsigned       NUM_BYTES    = 16,
    parameter int unsigned       PATTERN_MODE = 0,
    parameter logic [DATA_W-1:0] SEED         = 8'h2E,
    parameter logic [DATA_W-1:0] LFSR_TAPS    = 8'hB8,
    parameter int unsigned       TIMEOUT_CYC  = 100000,
    parameter bit                LOOP         = 1'b0
) (
    input  logic              CLK,
    input  logic              RST_n,
    input  logic              Start_Sig,
    output logic              Tx_En_Sig,
    output logic [DATA_W-1:0] Tx_Data,
    input  logic              Tx_Done_Sig,
    input  logic              Rx_Done_Sig,
    input  logic [DATA_W-1:0] Rx_Data,
    output logic              Busy,
    output logic              Done_Sig,
    output logic              Pass,
    output logic [15:0]       Err_Cnt,
    output logic [15:0]       Byte_Cnt,
    output logic              Timeout_Err
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_SEND, S_WAIT, S_CHECK, S_FINISH
    } state_t;

    localparam logic [15:0] LAST_BYTE = 16'(NUM_BYTES);
    localparam logic [31:0] TMO_LIM   = 32'(TIMEOUT_CYC - 1);

    state_t            state;
    logic [DATA_W-1:0] pattern;
    logic [DATA_W-1:0] expect_q;
    logic [DATA_W-1:0] rx_byte;
    logic              rx_got;
    logic              tx_done;
    logic              tmo_flag;
    logic [31:0]       tmo_cnt;

    logic        active;
    logic        rx_first;
    logic        rx_spur;
    logic        tmo_now;
    logic        mis;
    logic        err_clr;
    logic [1:0]  inc;
    logic [16:0] err_sum;
    logic [15:0] err_nxt;

    function automatic logic [DATA_W-1:0] next_pat(
        input logic [DATA_W-1:0] p
    );
        if (PATTERN_MODE == 1)
            return p[0] ? ((p >> 1) ^ LFSR_TAPS) : (p >> 1);
        else
            return p + {{(DATA_W-1){1'b0}}, 1'b1};
    endfunction

    // Every rx pulse other than the first one of a byte is an error.
    always_comb begin
        active   = (state == S_SEND) || (state == S_WAIT);
        rx_first = Rx_Done_Sig && active && !rx_got;
        rx_spur  = Rx_Done_Sig && !rx_first;
        tmo_now  = (tmo_cnt >= TMO_LIM) &&
                   (((state == S_SEND) && !Tx_Done_Sig) ||
                    ((state == S_WAIT) && !(tx_done && rx_got)));
        mis      = (state == S_CHECK) && !tmo_flag &&
                   (rx_byte != expect_q);
        err_clr  = ((state == S_IDLE) && Start_Sig) ||
                   ((state == S_FINISH) && LOOP);
        inc      = {1'b0, rx_spur} + {1'b0, tmo_now} + {1'b0, mis};
        err_sum  = (err_clr ? 17'd0 : {1'b0, Err_Cnt}) +
                   {15'd0, inc};
        err_nxt  = err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end

    assign Busy = (state != S_IDLE);

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state       <= S_IDLE;
            pattern     <= SEED;
            expect_q    <= '0;
            rx_byte     <= '0;
            rx_got      <= 1'b0;
            tx_done     <= 1'b0;
            tmo_flag    <= 1'b0;
            tmo_cnt     <= '0;
            Tx_En_Sig   <= 1'b0;
            Tx_Data     <= '0;
            Done_Sig    <= 1'b0;
            Pass        <= 1'b0;
            Err_Cnt     <= '0;
            Byte_Cnt    <= '0;
            Timeout_Err <= 1'b0;
        end else begin
            Done_Sig <= 1'b0;
            Err_Cnt  <= err_nxt;
            if (rx_first) begin
                rx_got  <= 1'b1;
                rx_byte <= Rx_Data;
            end
            if (active)
                tmo_cnt <= tmo_cnt + 32'd1;
            unique case (state)
                S_IDLE: begin
                    if (Start_Sig) begin
                        Byte_Cnt    <= '0;
                        Pass        <= 1'b0;
                        Timeout_Err <= 1'b0;
                        pattern     <= SEED;
                        state       <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    Tx_Data   <= pattern;
                    expect_q  <= pattern;
                    rx_got    <= 1'b0;
                    tx_done   <= 1'b0;
                    tmo_flag  <= 1'b0;
                    tmo_cnt   <= '0;
                    Tx_En_Sig <= 1'b1;
                    state     <= S_SEND;
                end
                S_SEND: begin
                    if (Tx_Done_Sig) begin
                        Tx_En_Sig <= 1'b0;
                        tx_done   <= 1'b1;
                        state     <= S_WAIT;
                    end else if (tmo_now) begin
                        Tx_En_Sig   <= 1'b0;
                        tmo_flag    <= 1'b1;
                        Timeout_Err <= 1'b1;
                        state       <= S_CHECK;
                    end
                end
                S_WAIT: begin
                    if (tx_done && rx_got) begin
                        state <= S_CHECK;
                    end else if (tmo_now) begin
                        tmo_flag    <= 1'b1;
                        Timeout_Err <= 1'b1;
                        state       <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    Byte_Cnt <= Byte_Cnt + 16'd1;
                    pattern  <= next_pat(pattern);
                    if (Byte_Cnt + 16'd1 == LAST_BYTE)
                        state <= S_FINISH;
                    else
                        state <= S_LOAD;
                end
                S_FINISH: begin
                    Done_Sig <= 1'b1;
                    Pass     <= (Err_Cnt == 16'd0) && (inc == 2'd0);
                    if (LOOP) begin
                        Byte_Cnt    <= '0;
                        Timeout_Err <= 1'b0;
                        pattern     <= SEED;
                        state       <= S_LOAD;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_loopback_seq.sv
// Scoreboard bench for uart_loopback_seq: an incrementing-pattern instance
// and an LFSR-pattern instance driven by a randomized tx/rx loopback model.
module tb_uart_loopback_seq;

    localparam int          N0 = 16;
    localparam logic [7:0]  S0 = 8'hF8;
    localparam int          N1 = 4;
    localparam logic [7:0]  S1 = 8'h01;
    localparam int          T  = 200;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic             RST_n;
    logic [1:0]       start, tx_done, rx_done;
    logic [1:0]       tx_en, busy, done, pass, tmo_err;
    logic [1:0][7:0]  tx_data, rx_data;
    logic [1:0][15:0] err_cnt, byte_cnt;

    uart_loopback_seq #(
        .NUM_BYTES(N0), .SEED(S0), .TIMEOUT_CYC(T)
    ) dut0 (
        .CLK(CLK), .RST_n(RST_n), .Start_Sig(start[0]),
        .Tx_En_Sig(tx_en[0]), .Tx_Data(tx_data[0]),
        .Tx_Done_Sig(tx_done[0]), .Rx_Done_Sig(rx_done[0]),
        .Rx_Data(rx_data[0]), .Busy(busy[0]), .Done_Sig(done[0]),
        .Pass(pass[0]), .Err_Cnt(err_cnt[0]),
        .Byte_Cnt(byte_cnt[0]), .Timeout_Err(tmo_err[0])
    );

    uart_loopback_seq #(
        .NUM_BYTES(N1), .PATTERN_MODE(1), .SEED(S1),
        .TIMEOUT_CYC(T)
    ) dut1 (
        .CLK(CLK), .RST_n(RST_n), .Start_Sig(start[1]),
        .Tx_En_Sig(tx_en[1]), .Tx_Data(tx_data[1]),
        .Tx_Done_Sig(tx_done[1]), .Rx_Done_Sig(rx_done[1]),
        .Rx_Data(rx_data[1]), .Busy(busy[1]), .Done_Sig(done[1]),
        .Pass(pass[1]), .Err_Cnt(err_cnt[1]),
        .Byte_Cnt(byte_cnt[1]), .Timeout_Err(tmo_err[1])
    );

    typedef struct packed {
        logic [15:0] err;
        logic [15:0] bytes;
        logic        pass;
        logic        tmo;
    } res_t;

    typedef struct {
        string       name;
        logic [31:0] act;
        logic [31:0] exp;
    } chk_t;

    logic [7:0] txq0[$], txq1[$];
    res_t       rq0[$], rq1[$];
    chk_t       cq[$];
    int         n_chk = 0;
    int         n_fail = 0;
    int         cyc = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    // Reference pattern: k-th byte of a run.
    function automatic logic [7:0] pat(input int i, input int k);
        logic [7:0] v;
        if (i == 0)
            return 8'((int'(S0) + k) % 256);
        v = S1;
        for (int j = 0; j < k; j++)
            v = v[0] ? ((v >> 1) ^ 8'hB8) : (v >> 1);
        return v;
    endfunction

    function automatic void post(input string n, input logic [31:0] a,
                                 input logic [31:0] e);
        chk_t c;
        c.name = n;
        c.act  = a;
        c.exp  = e;
        cq.push_back(c);
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever a DUT shows an output event.
    logic [1:0] en_d = '0;
    always @(negedge CLK) begin
        chk_t       c;
        logic [7:0] e8;
        res_t       r;
        while (cq.size() > 0) begin
            c = cq.pop_front();
            check(c.name, c.act, c.exp);
        end
        if (tx_en[0] && !en_d[0]) begin
            if (txq0.size() == 0) check("tx0_unexpected", 1, 0);
            else begin
                e8 = txq0.pop_front();
                check("tx0_data", 32'(tx_data[0]), 32'(e8));
            end
        end
        if (tx_en[1] && !en_d[1]) begin
            if (txq1.size() == 0) check("tx1_unexpected", 1, 0);
            else begin
                e8 = txq1.pop_front();
                check("tx1_data", 32'(tx_data[1]), 32'(e8));
            end
        end
        if (done[0]) begin
            if (rq0.size() == 0) check("done0_unexpected", 1, 0);
            else begin
                r = rq0.pop_front();
                check("err0", 32'(err_cnt[0]), 32'(r.err));
                check("bytes0", 32'(byte_cnt[0]), 32'(r.bytes));
                check("pass0", 32'(pass[0]), 32'(r.pass));
                check("tmo0", 32'(tmo_err[0]), 32'(r.tmo));
            end
        end
        if (done[1]) begin
            if (rq1.size() == 0) check("done1_unexpected", 1, 0);
            else begin
                r = rq1.pop_front();
                check("err1", 32'(err_cnt[1]), 32'(r.err));
                check("bytes1", 32'(byte_cnt[1]), 32'(r.bytes));
                check("pass1", 32'(pass[1]), 32'(r.pass));
                check("tmo1", 32'(tmo_err[1]), 32'(r.tmo));
            end
        end
        en_d = tx_en;
    end

    task automatic post_reset_vals(input int i);
        post("rst_tx_en", 32'(tx_en[i]), 0);
        post("rst_tx_data", 32'(tx_data[i]), 0);
        post("rst_busy", 32'(busy[i]), 0);
        post("rst_done", 32'(done[i]), 0);
        post("rst_pass", 32'(pass[i]), 0);
        post("rst_err", 32'(err_cnt[i]), 0);
        post("rst_bytes", 32'(byte_cnt[i]), 0);
        post("rst_tmo", 32'(tmo_err[i]), 0);
    endtask

    task automatic wait_en(input int i, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < T + 50; c++) begin
            if (tx_en[i]) begin
                ok = 1'b1;
                break;
            end
            @(posedge CLK); #1;
        end
    endtask

    // One run: bad = byte with corrupted bit 0, spur = byte with a
    // duplicate rx pulse, no_rx = rx never answers, abort = byte during
    // whose SEND reset is pulsed, kick = byte at which Start is re-pulsed.
    task automatic run(input int i, input int bad, input int spur,
                       input bit no_rx, input int abort, input int kick);
        int         n, ne, dt, dr, last, t0;
        res_t       r;
        bit         ok;
        logic [7:0] d;
        n = (i == 0) ? N0 : N1;
        for (int k = 0; k < n; k++)
            if (abort < 0 || k < abort) begin
                if (i == 0) txq0.push_back(pat(0, k));
                else txq1.push_back(pat(1, k));
            end
        ne = 0;
        if (bad >= 0) ne++;
        if (spur >= 0) ne++;
        if (no_rx) ne += n;
        r.err   = 16'(ne);
        r.bytes = 16'(n);
        r.pass  = (ne == 0);
        r.tmo   = no_rx;
        if (abort < 0) begin
            if (i == 0) rq0.push_back(r);
            else rq1.push_back(r);
        end
        start[i] = 1'b1;
        t0 = cyc;
        @(posedge CLK); #1;
        start[i] = 1'b0;
        for (int b = 0; b < n; b++) begin
            wait_en(i, ok);
            if (!ok) begin
                post("tx_en_wait", 0, 1);
                return;
            end
            if (b == abort) begin
                RST_n = 1'b0;
                #1;
                post_reset_vals(i);
                @(posedge CLK); #1;
                RST_n = 1'b1;
                @(posedge CLK); #1;
                post("idle_after_rst", 32'(busy[i]), 0);
                return;
            end
            d = tx_data[i];
            if (b == spur) begin
                dr = 0;
                dt = 4;
            end else begin
                dt = $urandom_range(0, 6);
                dr = $urandom_range(0, 8);
            end
            last = (dt > dr + 1) ? dt : dr + 1;
            for (int c = 0; c <= last; c++) begin
                tx_done[i] = (c == dt);
                rx_done[i] = !no_rx &&
                             ((c == dr) || (b == spur && c == dr + 1));
                rx_data[i] = (b == bad) ? (d ^ 8'h01) : d;
                start[i]   = (b == kick) && (c == 0);
                @(posedge CLK); #1;
            end
            tx_done[i] = 1'b0;
            rx_done[i] = 1'b0;
            start[i]   = 1'b0;
        end
        ok = 1'b0;
        for (int c = 0; c < T + 50; c++) begin
            if (!busy[i]) begin
                ok = 1'b1;
                break;
            end
            @(posedge CLK); #1;
        end
        post("run_ends", 32'(ok), 1);
        if (no_rx)
            post("tmo_latency",
                 32'((cyc - t0 >= n * T) && (cyc - t0 <= n * (T + 4))), 1);
        repeat (3) @(posedge CLK);
        #1;
        post("pass_held", 32'(pass[i]), 32'(r.pass));
    endtask

    initial begin
        RST_n   = 1'b0;
        start   = '0;
        tx_done = '0;
        rx_done = '0;
        rx_data = '0;
        repeat (3) @(posedge CLK);
        #1;
        post_reset_vals(0);
        post_reset_vals(1);
        RST_n = 1'b1;
        @(posedge CLK); #1;
        post("idle_no_start", 32'(busy[0]), 0);

        run(0, -1, -1, 1'b0, -1, -1);
        rx_done[0] = 1'b1;
        @(posedge CLK); #1;
        rx_done[0] = 1'b0;
        post("idle_spur_err", 32'(err_cnt[0]), 1);
        post("idle_spur_pass", 32'(pass[0]), 1);
        post("idle_spur_busy", 32'(busy[0]), 0);

        run(0, 3, -1, 1'b0, -1, 5);
        run(0, 10, 7, 1'b0, -1, -1);
        run(0, -1, -1, 1'b1, -1, -1);
        run(0, -1, -1, 1'b0, 4, -1);
        run(0, -1, -1, 1'b0, -1, -1);
        run(1, -1, -1, 1'b0, -1, -1);
        run(1, 0, -1, 1'b0, -1, -1);

        post("tx0_left", 32'(txq0.size()), 0);
        post("tx1_left", 32'(txq1.size()), 0);
        post("res0_left", 32'(rq0.size()), 0);
        post("res1_left", 32'(rq1.size()), 0);
        repeat (3) @(posedge CLK);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
